// File: rtl/lime_io_bridge.sv
// lime_io_bridge: buffered I/O stage between external valid/ready streams and
// the processor's main_input/main_output pair.
//  - Input FIFO: external producer -> first-word fall-through head on proc_input.
//  - Output FIFO: processor write strobes -> external consumer.
// Optional build macro LIME_IO_ERRFLAGS_EN enables sticky underrun/overrun
// flags; when undefined both flag outputs are tied to 0.
module lime_io_bridge #(
  parameter int WIDTH     = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              ext_in_data,
  input  logic                          ext_in_valid,
  output logic                          ext_in_ready,
  output logic [WIDTH-1:0]              proc_input,
  output logic                          proc_in_avail,
  input  logic                          proc_in_rd,
  input  logic [WIDTH-1:0]              proc_output,
  input  logic                          proc_out_wr,
  output logic                          proc_out_full,
  output logic [WIDTH-1:0]              ext_out_data,
  output logic                          ext_out_valid,
  input  logic                          ext_out_ready,
  output logic [$clog2(IN_DEPTH):0]     in_count,
  output logic [$clog2(OUT_DEPTH):0]    out_count,
  output logic                          err_in_underrun,
  output logic                          err_out_overrun
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [IN_AW:0]  IN_FULL  = (IN_AW + 1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL = (OUT_AW + 1)'(OUT_DEPTH);

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] in_mem [IN_DEPTH];
  logic [IN_AW-1:0] in_wr_ptr_q, in_wr_ptr_d;
  logic [IN_AW-1:0] in_rd_ptr_q, in_rd_ptr_d;
  logic [IN_AW:0]   in_count_q,  in_count_d;
  logic             in_push, in_pop;

  // Flow-control flags come from the registered count only, so there is no
  // combinational path from proc_in_rd to ext_in_ready.
  assign ext_in_ready  = (in_count_q != IN_FULL);
  assign proc_in_avail = (in_count_q != '0);
  assign proc_input    = proc_in_avail ? in_mem[in_rd_ptr_q] : '0;
  assign in_count      = in_count_q;

  // Next-state for input pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    in_push     = ext_in_valid & ext_in_ready;
    in_pop      = proc_in_rd & proc_in_avail;
    in_wr_ptr_d = in_wr_ptr_q;
    in_rd_ptr_d = in_rd_ptr_q;
    in_count_d  = in_count_q;
    if (in_push) in_wr_ptr_d = in_wr_ptr_q + IN_AW'(1);
    if (in_pop)  in_rd_ptr_d = in_rd_ptr_q + IN_AW'(1);
    case ({in_push, in_pop})
      2'b10:   in_count_d = in_count_q + (IN_AW + 1)'(1);
      2'b01:   in_count_d = in_count_q - (IN_AW + 1)'(1);
      default: in_count_d = in_count_q;
    endcase
  end

  // Input-side state registers; reset wins over any push or pop.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      in_wr_ptr_q <= '0;
      in_rd_ptr_q <= '0;
      in_count_q  <= '0;
    end else begin
      in_wr_ptr_q <= in_wr_ptr_d;
      in_rd_ptr_q <= in_rd_ptr_d;
      in_count_q  <= in_count_d;
    end
  end

  // Input storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: the storage array is deliberately not reset; the count gates every
    // read, so stale contents are never visible and the array maps onto plain
    // RAM/register cells without reset logic.
    if (!reset && in_push) in_mem[in_wr_ptr_q] <= ext_in_data;
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_ptr_q, out_wr_ptr_d;
  logic [OUT_AW-1:0] out_rd_ptr_q, out_rd_ptr_d;
  logic [OUT_AW:0]   out_count_q,  out_count_d;
  logic              out_push, out_pop;

  assign proc_out_full = (out_count_q == OUT_FULL);
  assign ext_out_valid = (out_count_q != '0);
  assign ext_out_data  = ext_out_valid ? out_mem[out_rd_ptr_q] : '0;
  assign out_count     = out_count_q;

  // Next-state for output pointers and occupancy.
  always_comb begin
    out_push     = proc_out_wr & ~proc_out_full;
    out_pop      = ext_out_valid & ext_out_ready;
    out_wr_ptr_d = out_wr_ptr_q;
    out_rd_ptr_d = out_rd_ptr_q;
    out_count_d  = out_count_q;
    if (out_push) out_wr_ptr_d = out_wr_ptr_q + OUT_AW'(1);
    if (out_pop)  out_rd_ptr_d = out_rd_ptr_q + OUT_AW'(1);
    case ({out_push, out_pop})
      2'b10:   out_count_d = out_count_q + (OUT_AW + 1)'(1);
      2'b01:   out_count_d = out_count_q - (OUT_AW + 1)'(1);
      default: out_count_d = out_count_q;
    endcase
  end

  // Output-side state registers; reset wins over any push or pop.
  always_ff @(posedge CLK) begin
    if (reset) begin
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_count_q  <= '0;
    end else begin
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_count_q  <= out_count_d;
    end
  end

  // Output storage write port.
  always_ff @(posedge CLK) begin
    if (!reset && out_push) out_mem[out_wr_ptr_q] <= proc_output;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef LIME_IO_ERRFLAGS_EN
  logic err_in_underrun_q, err_in_underrun_d;
  logic err_out_overrun_q, err_out_overrun_d;

  // Flags latch on any read while empty / write while full.
  always_comb begin
    err_in_underrun_d = err_in_underrun_q | (proc_in_rd & ~proc_in_avail);
    err_out_overrun_d = err_out_overrun_q | (proc_out_wr & proc_out_full);
  end

  // Flags clear only on reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      err_in_underrun_q <= 1'b0;
      err_out_overrun_q <= 1'b0;
    end else begin
      err_in_underrun_q <= err_in_underrun_d;
      err_out_overrun_q <= err_out_overrun_d;
    end
  end

  assign err_in_underrun = err_in_underrun_q;
  assign err_out_overrun = err_out_overrun_q;
`else
  assign err_in_underrun = 1'b0;
  assign err_out_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_lime_io_bridge.sv
// Directed, table-driven bench for lime_io_bridge (default parameters).
// Each table row holds the inputs applied before a rising edge and the outputs
// expected after that edge.
module tb_lime_io_bridge;

  localparam int WIDTH = 16;
`ifdef LIME_IO_ERRFLAGS_EN
  localparam logic EF = 1'b1;
`else
  localparam logic EF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic [WIDTH-1:0] proc_input;
  logic             proc_in_avail;
  logic             proc_in_rd;
  logic [WIDTH-1:0] proc_output;
  logic             proc_out_wr;
  logic             proc_out_full;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic [2:0]       in_count;
  logic [2:0]       out_count;
  logic             err_in_underrun;
  logic             err_out_overrun;

  lime_io_bridge #(.WIDTH(WIDTH), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .ext_in_data    (ext_in_data),
    .ext_in_valid   (ext_in_valid),
    .ext_in_ready   (ext_in_ready),
    .proc_input     (proc_input),
    .proc_in_avail  (proc_in_avail),
    .proc_in_rd     (proc_in_rd),
    .proc_output    (proc_output),
    .proc_out_wr    (proc_out_wr),
    .proc_out_full  (proc_out_full),
    .ext_out_data   (ext_out_data),
    .ext_out_valid  (ext_out_valid),
    .ext_out_ready  (ext_out_ready),
    .in_count       (in_count),
    .out_count      (out_count),
    .err_in_underrun(err_in_underrun),
    .err_out_overrun(err_out_overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] id;
    logic        rd;
    logic        wr;
    logic [15:0] wd;
    logic        ordy;
    logic        e_irdy;
    logic        e_avail;
    logic [15:0] e_pin;
    logic [2:0]  e_icnt;
    logic        e_ofull;
    logic        e_ovld;
    logic [15:0] e_odata;
    logic [2:0]  e_ocnt;
    logic        e_eu;
    logic        e_eo;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic iv, input logic [15:0] id, input logic rd,
                     input logic wr, input logic [15:0] wd, input logic ordy,
                     input logic e_irdy, input logic e_avail, input logic [15:0] e_pin,
                     input logic [2:0] e_icnt, input logic e_ofull, input logic e_ovld,
                     input logic [15:0] e_odata, input logic [2:0] e_ocnt,
                     input logic e_eu, input logic e_eo);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.rd = rd; v.wr = wr; v.wd = wd; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_avail = e_avail; v.e_pin = e_pin; v.e_icnt = e_icnt;
    v.e_ofull = e_ofull; v.e_ovld = e_ovld; v.e_odata = e_odata; v.e_ocnt = e_ocnt;
    v.e_eu = e_eu; v.e_eo = e_eo;
    vecs.push_back(v);
  endtask

  // Drive inputs (called at a falling edge), cross one rising edge, return at
  // the following falling edge where outputs are sampled.
  task automatic cycle(input logic rst, input logic iv, input logic [15:0] id, input logic rd,
                       input logic wr, input logic [15:0] wd, input logic ordy);
    reset = rst; ext_in_valid = iv; ext_in_data = id; proc_in_rd = rd;
    proc_out_wr = wr; proc_output = wd; ext_out_ready = ordy;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".ext_in_ready"},    32'(ext_in_ready),    32'(v.e_irdy));
    check({tag, ".proc_in_avail"},   32'(proc_in_avail),   32'(v.e_avail));
    check({tag, ".proc_input"},      32'(proc_input),      32'(v.e_pin));
    check({tag, ".in_count"},        32'(in_count),        32'(v.e_icnt));
    check({tag, ".proc_out_full"},   32'(proc_out_full),   32'(v.e_ofull));
    check({tag, ".ext_out_valid"},   32'(ext_out_valid),   32'(v.e_ovld));
    check({tag, ".ext_out_data"},    32'(ext_out_data),    32'(v.e_odata));
    check({tag, ".out_count"},       32'(out_count),       32'(v.e_ocnt));
    check({tag, ".err_in_underrun"}, 32'(err_in_underrun), 32'(v.e_eu));
    check({tag, ".err_out_overrun"}, 32'(err_out_overrun), 32'(v.e_eo));
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; ext_in_valid = 1'b0; ext_in_data = '0; proc_in_rd = 1'b0;
    proc_out_wr = 1'b0; proc_output = '0; ext_out_ready = 1'b0;

    //   rst iv  id       rd wr wd       ordy | irdy av pin      ic ofu ov odata    oc eu  eo
    // Reset state
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0,  0);
    // Single word through the input side
    add(0, 1, 16'h1234, 0, 0, 16'h0000, 0,   1, 1, 16'h1234, 1, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0,  0);
    // Fill with 1..4, 5 refused while full
    add(0, 1, 16'h0001, 0, 0, 16'h0000, 0,   1, 1, 16'h0001, 1, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0002, 0, 0, 16'h0000, 0,   1, 1, 16'h0001, 2, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0003, 0, 0, 16'h0000, 0,   1, 1, 16'h0001, 3, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0004, 0, 0, 16'h0000, 0,   0, 1, 16'h0001, 4, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0005, 0, 0, 16'h0000, 0,   0, 1, 16'h0001, 4, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 1, 16'h0002, 3, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 1, 16'h0003, 2, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 1, 16'h0004, 1, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0,  0);
    // Full input FIFO with simultaneous push+pop, pointers wrap
    add(0, 1, 16'h0011, 0, 0, 16'h0000, 0,   1, 1, 16'h0011, 1, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0012, 0, 0, 16'h0000, 0,   1, 1, 16'h0011, 2, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0013, 0, 0, 16'h0000, 0,   1, 1, 16'h0011, 3, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0014, 0, 0, 16'h0000, 0,   0, 1, 16'h0011, 4, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0015, 1, 0, 16'h0000, 0,   1, 1, 16'h0012, 3, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 1, 16'h0016, 1, 0, 16'h0000, 0,   1, 1, 16'h0013, 3, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 1, 16'h0014, 2, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 1, 16'h0016, 1, 0, 0, 16'h0000, 0, 0,  0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0,  0);
    // Empty input FIFO: push+read -> read ignored (underrun), push lands
    add(0, 1, 16'h0021, 1, 0, 16'h0000, 0,   1, 1, 16'h0021, 1, 0, 0, 16'h0000, 0, EF, 0);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, EF, 0);
    // Output side: two writes held, then drained
    add(0, 0, 16'h0000, 0, 1, 16'hA5A5, 0,   1, 0, 16'h0000, 0, 0, 1, 16'hA5A5, 1, EF, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h5A5A, 0,   1, 0, 16'h0000, 0, 0, 1, 16'hA5A5, 2, EF, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 0, 16'h0000, 0, 0, 1, 16'hA5A5, 2, EF, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0, 1, 16'h5A5A, 1, EF, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, EF, 0);
    // Fill output FIFO, overrun drop, full push+pop
    add(0, 0, 16'h0000, 0, 1, 16'h0B01, 0,   1, 0, 16'h0000, 0, 0, 1, 16'h0B01, 1, EF, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h0B02, 0,   1, 0, 16'h0000, 0, 0, 1, 16'h0B01, 2, EF, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h0B03, 0,   1, 0, 16'h0000, 0, 0, 1, 16'h0B01, 3, EF, 0);
    add(0, 0, 16'h0000, 0, 1, 16'h0B04, 0,   1, 0, 16'h0000, 0, 1, 1, 16'h0B01, 4, EF, 0);
    add(0, 0, 16'h0000, 0, 1, 16'hDEAD, 0,   1, 0, 16'h0000, 0, 1, 1, 16'h0B01, 4, EF, EF);
    add(0, 0, 16'h0000, 0, 1, 16'hBEEF, 1,   1, 0, 16'h0000, 0, 0, 1, 16'h0B02, 3, EF, EF);
    add(0, 0, 16'h0000, 0, 1, 16'hC0DE, 1,   1, 0, 16'h0000, 0, 0, 1, 16'h0B03, 3, EF, EF);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0, 1, 16'h0B04, 2, EF, EF);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0, 1, 16'hC0DE, 1, EF, EF);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, EF, EF);
    // Empty output FIFO: write+ready -> pop ignored, write lands
    add(0, 0, 16'h0000, 0, 1, 16'h0077, 1,   1, 0, 16'h0000, 0, 0, 1, 16'h0077, 1, EF, EF);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, EF, EF);

    @(negedge CLK);
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].ordy);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-operation: three words in each FIFO, reset with all strobes high.
    for (int k = 0; k < 3; k++)
      cycle(0, 1, 16'(16'h0031 + k), 0, 1, 16'(16'h0041 + k), 0);
    check("preload.in_count",  32'(in_count),  32'd3);
    check("preload.out_count", 32'(out_count), 32'd3);
    check("preload.proc_input",   32'(proc_input),   32'h0031);
    check("preload.ext_out_data", 32'(ext_out_data), 32'h0041);
    check("preload.err_in_underrun_sticky", 32'(err_in_underrun), 32'(EF));
    check("preload.err_out_overrun_sticky", 32'(err_out_overrun), 32'(EF));
    cycle(1, 1, 16'h0099, 1, 1, 16'h0088, 1);
    v = '{rst:0, iv:0, id:0, rd:0, wr:0, wd:0, ordy:0,
          e_irdy:1, e_avail:0, e_pin:0, e_icnt:0, e_ofull:0, e_ovld:0, e_odata:0,
          e_ocnt:0, e_eu:0, e_eo:0};
    check_all("midreset", v);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    check_all("postreset_idle", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lime_io_bridge.md
Name: lime_io_bridge

Overview:
- Buffered I/O stage that sits between the external world and the processor top's 16-bit main_input/main_output pair.
- Input side: words from an external valid/ready producer go into a small FIFO. The head word is presented as the processor's input value and is popped when the processor reads it.
- Output side: processor output writes are captured into a second FIFO and drained to an external valid/ready consumer.
- Decouples processor timing from I/O timing so no word is lost or duplicated.

Parameters:
- WIDTH, 16, data word width; matches processor datapath.
- IN_DEPTH, 4, input FIFO depth; power of two, ≥2.
- OUT_DEPTH, 4, output FIFO depth; power of two, ≥2.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; flushes both FIFOs.
- ext_in_data  in  WIDTH  word from external producer.
- ext_in_valid  in  1  ext_in_data valid.
- ext_in_ready  out  1  input FIFO can accept a word.
- proc_input  out  WIDTH  head of input FIFO; drives processor main_input.
- proc_in_avail  out  1  input FIFO non-empty.
- proc_in_rd  in  1  one-cycle strobe: processor consumed proc_input.
- proc_output  in  WIDTH  processor main_output value.
- proc_out_wr  in  1  one-cycle strobe: processor wrote proc_output.
- proc_out_full  out  1  output FIFO full.
- ext_out_data  out  WIDTH  head of output FIFO.
- ext_out_valid  out  1  output FIFO non-empty.
- ext_out_ready  in  1  external consumer accepts ext_out_data.
- in_count  out  clog2(IN_DEPTH)+1  input FIFO occupancy.
- out_count  out  clog2(OUT_DEPTH)+1  output FIFO occupancy.
- err_in_underrun  out  1  sticky error flag (see Optional Feature).
- err_out_overrun  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high.
- Reset values:
  - Pointers and counts = 0.
  - ext_in_ready = 1, proc_in_avail = 0, proc_input = 0x0000.
  - ext_out_valid = 0, ext_out_data = 0x0000, proc_out_full = 0.
  - Error flags = 0.
- Reset mid-operation: all buffered words are discarded, with no partial handshake. reset has priority over every push and pop in the same cycle.
- Input FIFO:
  - Push when ext_in_valid & ext_in_ready.
  - ext_in_ready = (in_count != IN_DEPTH), derived from registered count only; no combinational path from proc_in_rd.
  - Pop when proc_in_rd & proc_in_avail.
  - proc_in_rd while empty: no pointer change (underrun).
- Input-side presentation:
  - First-word fall-through. A word pushed at edge N appears on proc_input, with proc_in_avail = 1, in the cycle after edge N.
  - When empty, proc_input = 0x0000.
- Output FIFO:
  - Push when proc_out_wr & !proc_out_full.
  - proc_out_wr while full: word dropped, contents unchanged (overrun).
  - Pop when ext_out_valid & ext_out_ready.
  - ext_out_valid = (out_count != 0).
  - ext_out_data = head word, stable while valid & !ready.
- Simultaneous push and pop on the same FIFO:
  - Count unchanged; both pointers advance.
  - When full, a simultaneous pop does not enable the push (ready/full are from registered count).
  - When empty, the pop is ignored and the push proceeds.
- Pointer arithmetic: pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Counts saturate structurally at DEPTH and never exceed it.
- Latency:
  - External input to processor: 1 cycle.
  - Processor write to ext_out_valid: 1 cycle.
- Ordering: strict FIFO order on both sides.

Optional Feature:
- Macro: LIME_IO_ERRFLAGS_EN.
- Defined:
  - err_in_underrun sets on any proc_in_rd while empty.
  - err_out_overrun sets on any proc_out_wr while full.
  - Both are sticky until reset.
- Undefined: both ports tied to 0 and no flag logic is synthesized; FIFO behaviour is identical.

Test Plan:
- Reset, then push 0x1234 (valid = 1 for one cycle) → next cycle proc_input = 0x1234, proc_in_avail = 1, in_count = 1; pulse proc_in_rd → next cycle proc_input = 0x0000, in_count = 0.
- Push 0x0001..0x0004 back-to-back, then hold valid with 0x0005 → ext_in_ready = 0 after the 4th push and 0x0005 is not accepted; pop four times → reads 1, 2, 3, 4 in order, then ext_in_ready = 1.
- With IN_DEPTH = 4 full, assert push and proc_in_rd in the same cycle → one pop only, in_count = 3; next cycle push + pop → in_count stays 3, order preserved.
- proc_out_wr with 0xA5A5, 0x5A5A while ext_out_ready = 0 → ext_out_valid = 1, ext_out_data holds 0xA5A5; raise ready for 2 cycles → 0xA5A5 then 0x5A5A drained, valid = 0.
- Fill output FIFO (4 words), pulse proc_out_wr with 0xDEAD → dropped, out_count = 4; with LIME_IO_ERRFLAGS_EN, err_out_overrun = 1 and stays 1. proc_in_rd when empty → err_in_underrun = 1. Without the macro both flags remain 0.
- Load 3 words in each FIFO, assert reset for one cycle alongside push/pop strobes → next cycle counts = 0, ext_in_ready = 1, ext_out_valid = 0, proc_input = 0x0000, flags cleared.
